// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the count-down timer, with the same
// hour/minute/second widths and limits as the time-of-day counters.
package countdown_timer_pkg;

   localparam int unsigned SEC_W = 6;
   localparam int unsigned MIN_W = 6;
   localparam int unsigned HR_W  = 4;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
   localparam logic [HR_W-1:0]  HR_MAX  = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   typedef struct packed {
      logic [HR_W-1:0]  hr;
      logic [MIN_W-1:0] min;
      logic [SEC_W-1:0] sec;
   } hms_t;

   localparam hms_t HMS_ONE_SEC = '{hr: '0, min: '0, sec: 6'd1};

   function automatic logic hms_legal(input hms_t v);
      return (v.hr <= HR_MAX) && (v.min <= MIN_MAX) && (v.sec <= SEC_MAX);
   endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides the system clock into one-second ticks while enabled; holds its
// phase when disabled so a resumed count continues mid-second.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign tick = enable && !clear && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Kitchen-timer style H:M:S count-down: load a duration, run/pause, and
// flag expiry when the count reaches 0:00:00.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [HR_W-1:0]  load_hours,
   input  logic [MIN_W-1:0] load_minutes,
   input  logic [SEC_W-1:0] load_seconds,
   input  logic             start,
   input  logic             pause,
   output logic [HR_W-1:0]  hours,
   output logic [MIN_W-1:0] minutes,
   output logic [SEC_W-1:0] seconds,
   output logic             running,
   output logic             expired,
   output logic             load_err
);

   state_e state_q, state_d;
   hms_t   cnt_q, cnt_d;
   logic   running_q, running_d;
   logic   expired_q, expired_d;
   logic   load_err_q, load_err_d;

   hms_t load_v;
   hms_t cnt_dec;
   logic load_ok;
   logic cnt_zero;
   logic start_go;
   logic pause_go;
   logic ps_enable;
   logic ps_clear;
   logic tick;

   assign load_v   = {load_hours, load_minutes, load_seconds};
   assign load_ok  = hms_legal(load_v);
   assign cnt_zero = (cnt_q == '0);

   // A start seen in RUN is ignored, so it must not mask a concurrent pause.
   assign start_go = !load && start &&
                     (((state_q == ST_IDLE) && !cnt_zero) || (state_q == ST_PAUSED));
   assign pause_go = !load && !start_go && pause && (state_q == ST_RUN);

   // The prescaler only advances on cycles that actually stay in RUN.
   assign ps_enable = (state_q == ST_RUN) && !load && !pause;
   assign ps_clear  = (load && load_ok) || (start_go && (state_q == ST_IDLE));

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .enable(ps_enable),
      .clear (ps_clear),
      .tick  (tick)
   );

   always_comb begin
      cnt_dec = cnt_q;
      if (cnt_q.sec != '0) begin
         cnt_dec.sec = cnt_q.sec - 1'b1;
      end else if (cnt_q.min != '0) begin
         cnt_dec.sec = SEC_MAX;
         cnt_dec.min = cnt_q.min - 1'b1;
      end else if (cnt_q.hr != '0) begin
         cnt_dec.sec = SEC_MAX;
         cnt_dec.min = MIN_MAX;
         cnt_dec.hr  = cnt_q.hr - 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      expired_d  = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_ok) begin
            cnt_d   = load_v;
            state_d = ST_IDLE;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (start_go) begin
         state_d = ST_RUN;
      end else if (pause_go) begin
         state_d = ST_PAUSED;
      end else if (tick) begin
         cnt_d = cnt_dec;
         if (cnt_q == HMS_ONE_SEC) begin
            state_d   = ST_DONE;
            expired_d = 1'b1;
         end
      end
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         running_q  <= 1'b0;
         expired_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         running_q  <= running_d;
         expired_q  <= expired_d;
         load_err_q <= load_err_d;
      end
   end

   assign hours    = cnt_q.hr;
   assign minutes  = cnt_q.min;
   assign seconds  = cnt_q.sec;
   assign running  = running_q;
   assign expired  = expired_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table, multi-cycle
// corner sequences and randomized traffic against a seconds-based model.
module tb_countdown_timer;

   typedef struct packed {
      logic [3:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic       run;
      logic       exp;
      logic       lerr;
   } obs_t;

   typedef struct {
      bit rst, ld;
      int lh, lm, ls;
      bit st, ps;
      int eh, em, es;
      bit er, ee, el;
   } vec_t;

   // Model: remaining duration as a plain number of seconds.
   typedef struct {
      int rem;
      int mode;   // 0 idle, 1 run, 2 paused, 3 done
      int pc;
      bit exp;
      bit lerr;
   } mdl_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, load, start, pause;
   logic [3:0] lh;
   logic [5:0] lm, ls;
   logic [3:0] h1, h4;
   logic [5:0] m1, s1, m4, s4;
   logic       run1, exp1, le1, run4, exp4, le4;

   int checks = 0;
   int errors = 0;

   countdown_timer #(.TICK_DIV(1)) u_div1 (
      .clk(clk), .reset(reset), .load(load),
      .load_hours(lh), .load_minutes(lm), .load_seconds(ls),
      .start(start), .pause(pause),
      .hours(h1), .minutes(m1), .seconds(s1),
      .running(run1), .expired(exp1), .load_err(le1)
   );

   countdown_timer #(.TICK_DIV(4)) u_div4 (
      .clk(clk), .reset(reset), .load(load),
      .load_hours(lh), .load_minutes(lm), .load_seconds(ls),
      .start(start), .pause(pause),
      .hours(h4), .minutes(m4), .seconds(s4),
      .running(run4), .expired(exp4), .load_err(le4)
   );

   function automatic string fmt(input obs_t o);
      return $sformatf("%0d:%0d:%0d run=%0b exp=%0b lerr=%0b",
                       o.h, o.m, o.s, o.run, o.exp, o.lerr);
   endfunction

   function automatic obs_t mk_obs(input int h, m, s, input bit r, e, l);
      obs_t o;
      o.h = 4'(h); o.m = 6'(m); o.s = 6'(s);
      o.run = r; o.exp = e; o.lerr = l;
      return o;
   endfunction

   function automatic obs_t obs1();
      return {h1, m1, s1, run1, exp1, le1};
   endfunction

   function automatic obs_t obs4();
      return {h4, m4, s4, run4, exp4, le4};
   endfunction

   task automatic chk(input string name, input obs_t act, input obs_t req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(req));
      end
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic drive(input bit r, ld, input int h, m, s, input bit st, ps);
      reset = r; load = ld; lh = 4'(h); lm = 6'(m); ls = 6'(s);
      start = st; pause = ps;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void mstep(inout mdl_t md, input int div,
                                 input bit r, ld, input int h, m, s,
                                 input bit st, ps);
      md.exp  = 0;
      md.lerr = 0;
      if (!r) begin
         md.rem = 0; md.mode = 0; md.pc = 0;
      end else if (ld) begin
         if (h <= 12 && m <= 59 && s <= 59) begin
            md.rem = h * 3600 + m * 60 + s; md.mode = 0; md.pc = 0;
         end else begin
            md.lerr = 1;
         end
      end else if (st && ((md.mode == 0 && md.rem != 0) || md.mode == 2)) begin
         if (md.mode == 0) md.pc = 0;
         md.mode = 1;
      end else if (ps && md.mode == 1) begin
         md.mode = 2;
      end else if (md.mode == 1) begin
         if (md.pc == div - 1) begin
            md.pc = 0;
            md.rem--;
            if (md.rem == 0) begin
               md.mode = 3;
               md.exp  = 1;
            end
         end else begin
            md.pc++;
         end
      end
   endfunction

   function automatic obs_t mobs(input mdl_t md);
      return mk_obs(md.rem / 3600, (md.rem % 3600) / 60, md.rem % 60,
                    md.mode == 1, md.exp, md.lerr);
   endfunction

   function automatic vec_t mkv(input bit rst, ld, input int h, m, s, input bit st, ps,
                                input int eh, em, es, input bit er, ee, el);
      vec_t v;
      v.rst = rst; v.ld = ld; v.lh = h; v.lm = m; v.ls = s; v.st = st; v.ps = ps;
      v.eh = eh; v.em = em; v.es = es; v.er = er; v.ee = ee; v.el = el;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      int   pst;
      int   runcnt;
      bit   seen_exp;
      bit   was_run;
      mdl_t md1, md4;

      //            rst ld  h  m  s st ps   eh em es r e l
      tbl.push_back(mkv(0, 1, 5, 0, 0, 1, 0,  0, 0, 0, 0,0,0));
      tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 0,  1, 0, 0, 1,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0,59,59, 1,0,0));
      tbl.push_back(mkv(1, 1,13, 0, 0, 0, 0,  0,59,59, 1,0,1));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0,59,58, 1,0,0));
      tbl.push_back(mkv(1, 1, 0,60, 0, 0, 0,  0,59,58, 1,0,1));
      tbl.push_back(mkv(1, 1, 0, 0,60, 0, 0,  0,59,58, 1,0,1));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 1,  0,59,58, 0,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0,59,58, 0,0,0));
      tbl.push_back(mkv(1, 1,12,59,59, 0, 0, 12,59,59, 0,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 12,59,59, 1,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 1, 12,59,59, 0,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 0, 12,59,59, 1,0,0));
      tbl.push_back(mkv(1, 1, 0, 0, 5, 0, 0,  0, 0, 5, 0,0,0));
      tbl.push_back(mkv(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0,0,0));
      tbl.push_back(mkv(1, 1, 0, 0, 2, 0, 0,  0, 0, 2, 0,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 0,  0, 0, 2, 1,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,1,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0,0,0));
      tbl.push_back(mkv(1, 1, 0, 0, 3, 0, 0,  0, 0, 3, 0,0,0));
      tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 0,  0, 0, 3, 1,0,0));
      tbl.push_back(mkv(0, 1, 9, 9, 9, 1, 0,  0, 0, 0, 0,0,0));

      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].ld, tbl[i].lh, tbl[i].lm, tbl[i].ls, tbl[i].st, tbl[i].ps);
         step();
         chk($sformatf("vec%0d", i), obs1(),
             mk_obs(tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].er, tbl[i].ee, tbl[i].el));
      end

      // 0:01:02 at one tick per cycle: expiry lands on the 62nd tick.
      drive(1, 1, 0, 1, 2, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 1, 0);
      step();
      chk("run62_start", obs1(), mk_obs(0, 1, 2, 1, 0, 0));
      drive(1, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 62; k++) begin
         step();
         chk($sformatf("run62_tick%0d", k), obs1(),
             mk_obs(0, (62 - k) / 60, (62 - k) % 60, k < 62, k == 62, 0));
      end
      step();
      chk("run62_after", obs1(), mk_obs(0, 0, 0, 0, 0, 0));

      // TICK_DIV=4: 10 s with a 7-cycle pause after two ticks -> 40 RUN cycles.
      drive(1, 1, 0, 0, 10, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 1, 0);
      step();
      chk("div4_start", obs4(), mk_obs(0, 0, 10, 1, 0, 0));
      pst = 0; runcnt = 0; seen_exp = 0;
      for (int c = 0; c < 300 && !seen_exp; c++) begin
         if (pst == 0 && run4 && s4 == 6'd8) pst = 1;
         was_run = run4;
         drive(1, 0, 0, 0, 0, pst == 8, pst >= 1 && pst <= 7);
         step();
         if (was_run && !pause) runcnt++;
         if (pst == 4) chk("div4_paused", obs4(), mk_obs(0, 0, 8, 0, 0, 0));
         if (pst >= 1 && pst <= 8) pst++;
         seen_exp = exp4;
      end
      chk_int("div4_expired_seen", int'(seen_exp), 1);
      chk_int("div4_run_cycles", runcnt, 40);
      chk("div4_final", obs4(), mk_obs(0, 0, 0, 0, 1, 0));

      // Randomized traffic on both instances against the seconds model.
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      md1 = '{0, 0, 0, 0, 0};
      md4 = '{0, 0, 0, 0, 0};
      for (int c = 0; c < 3000; c++) begin
         bit r, ld, st, ps;
         int h, m, s;
         r  = ($urandom_range(0, 299) != 0);
         ld = ($urandom_range(0, 24) == 0);
         h  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 0;
         m  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
         s  = int'($urandom_range(0, 63));
         st = ($urandom_range(0, 4) == 0);
         ps = ($urandom_range(0, 11) == 0);
         drive(r, ld, h, m, s, st, ps);
         step();
         mstep(md1, 1, r, ld, h, m, s, st, ps);
         mstep(md4, 4, r, ld, h, m, s, st, ps);
         chk($sformatf("rnd1_c%0d", c), obs1(), mobs(md1));
         chk($sformatf("rnd4_c%0d", c), obs4(), mobs(md4));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Count-down counterpart to the 12-hour time-of-day counter chain: loads an H:M:S duration, then decrements once per second tick until 0:00:00 and flags expiry. It uses the same hours/minutes/seconds widths and ranges as the time-of-day counters. It sits beside them as the kitchen-timer/alarm-duration function of the clock design, driven by the same system clock.

## Interface
- TICK_DIV, default 1: clk cycles per one-second tick; 1 means every RUN cycle is a tick.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- load  in  1  one-cycle request to load load_hours/load_minutes/load_seconds.
- load_hours  in  4  duration hours, legal 0..12.
- load_minutes  in  6  duration minutes, legal 0..59.
- load_seconds  in  6  duration seconds, legal 0..59.
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- hours  out  4  remaining hours.
- minutes  out  6  remaining minutes.
- seconds  out  6  remaining seconds.
- running  out  1  high while in RUN.
- expired  out  1  one-cycle pulse when the count reaches 0:00:00.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSED: counting suspended.
  - DONE: count reached zero.
- Reset (reset==0 at posedge): state IDLE; hours/minutes/seconds 0; running, expired and load_err 0; prescaler 0.
- Input priority in one cycle: load > start > pause.
- load, any state:
  - Legal values: outputs take the load values, state becomes IDLE, prescaler clears.
  - Illegal values (hours>12, minutes>59 or seconds>59): load_err pulses, state and counts are unchanged.
- start:
  - IDLE with nonzero count: go to RUN, prescaler clears.
  - PAUSED: go to RUN, prescaler keeps its value.
  - IDLE with 0:00:00, RUN, or DONE: ignored.
- pause in RUN: go to PAUSED. Ignored in all other states.
- Tick: in RUN, when the prescaler equals TICK_DIV-1. The prescaler then wraps to 0; otherwise it increments. The prescaler only advances in RUN.
- Decrement on tick, with borrow:
  - seconds>0: seconds-1.
  - seconds==0, minutes>0: seconds=59, minutes-1.
  - seconds==0, minutes==0, hours>0: seconds=59, minutes=59, hours-1.
- A tick taking the count from 0:00:01 to 0:00:00 moves the state to DONE and asserts expired in that same update. expired, the zero count and DONE are all visible together after that edge.
- DONE holds 0:00:00 until a legal load.
- Hours never wrap; the 12→1 wrap used by the time-of-day counter does not apply here. The maximum duration is 12:59:59.

## Timing
- All outputs are registered. Every response appears on the first posedge after the causing input is sampled.
- load to new outputs: 1 cycle.
- start to running=1: 1 cycle.
- With TICK_DIV=1: the first decrement is visible 2 edges after start is sampled (edge 1 enters RUN, edge 2 is the first tick). Each later edge is one tick.
- With TICK_DIV=N: ticks come every N cycles in RUN, the first one N cycles after entering RUN.
- pause and a tick in the same cycle: pause wins, no decrement.
- load while RUN on a tick cycle: load wins, no decrement, state IDLE.
- expired and load_err are high for exactly one cycle and never repeat without a new cause.
- reset low during RUN or DONE aborts at the next edge to the full reset state, regardless of other inputs.

## Structure
- Shared package:
  - State enum (IDLE, RUN, PAUSED, DONE).
  - Constants SEC_MAX=59, MIN_MAX=59, HR_MAX=12.
  - Width constants 6/6/4, shared with the time-of-day counters.
- One sub-module, tick_prescaler (TICK_DIV): inputs clk, reset, enable, clear; output tick. The FSM and the borrow chain live in countdown_timer.

## Test plan
- Reset with load=1 and start=1 held → outputs 0:00:00, running=0, expired=0, load_err=0.
- TICK_DIV=1: load 0:01:02, start → sequence 0:01:01, 0:01:00, 0:00:59 … 0:00:00. expired pulses once, exactly on the 62nd tick; running drops on the same edge.
- Borrow across hours: load 1:00:00, start → next tick gives 0:59:59. Load 12:59:59 is accepted.
- Illegal loads: 13:00:00, 0:60:00 and 0:00:60 each pulse load_err once and leave the prior count and state intact.
- TICK_DIV=4: load 0:00:10, start; pause after 2 ticks for 7 cycles; resume → total elapsed RUN cycles at expiry equal 40.
- Load 0:00:05 during RUN on a tick cycle → 0:00:05, IDLE, no decrement. Start at 0:00:00 → stays IDLE, no expired. reset low mid-RUN → full reset state at the next edge.
